// File: rtl/bsg_manycore_link_sdr_channel_mux.sv
// bsg_manycore_link_sdr_channel_mux
//
// Core-side concentrator. It multiplexes num_channels_p credit-managed manycore link channels
// onto one SDR valid/data/token link, and demultiplexes inbound words back into per-channel
// receive FIFOs. Each channel has its own credit loop, so one stalled channel never blocks
// the others.
//
// Ports:
//   core_clk_i, core_reset_i        : clock; synchronous active-high reset
//   core_v_i/core_data_i            : per-channel transmit request
//   core_ready_and_o                : per-channel transmit accept (only the granted channel)
//   core_v_o/core_data_o            : per-channel receive FIFO head
//   core_yumi_i                     : per-channel receive dequeue
//   link_v_o/link_data_o            : outbound word {tag, payload}
//   link_token_i                    : per-channel inbound credit-return pulses
//   link_v_i/link_data_i            : inbound word {tag, payload}
//   link_token_o                    : per-channel outbound credit-return pulses
//
// Build option: define BSG_MANYCORE_LINK_SDR_MUX_TX_REG_EN to register link_v_o/link_data_o
// (1-cycle transmit latency). Otherwise they come straight from the arbiter mux.
module bsg_manycore_link_sdr_channel_mux #(
    parameter int unsigned num_channels_p                  = 2,
    parameter int unsigned width_p                         = 16,
    parameter int unsigned lg_fifo_depth_p                 = 3,
    parameter int unsigned lg_credit_to_token_decimation_p = 1,
    localparam int unsigned tag_width_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                    core_clk_i,
    input  logic                                    core_reset_i,

    input  logic [num_channels_p-1:0]               core_v_i,
    input  logic [num_channels_p-1:0][width_p-1:0]  core_data_i,
    output logic [num_channels_p-1:0]               core_ready_and_o,

    output logic [num_channels_p-1:0]               core_v_o,
    output logic [num_channels_p-1:0][width_p-1:0]  core_data_o,
    input  logic [num_channels_p-1:0]               core_yumi_i,

    output logic                                    link_v_o,
    output logic [width_p+tag_width_lp-1:0]         link_data_o,
    input  logic [num_channels_p-1:0]               link_token_i,

    input  logic                                    link_v_i,
    input  logic [width_p+tag_width_lp-1:0]         link_data_i,
    output logic [num_channels_p-1:0]               link_token_o
);

    localparam int unsigned Depth   = 1 << lg_fifo_depth_p;
    localparam int unsigned TokInc  = 1 << lg_credit_to_token_decimation_p;
    localparam int unsigned CreditW = lg_fifo_depth_p + 1;
    localparam int unsigned PtrW    = (lg_fifo_depth_p > 0) ? lg_fifo_depth_p : 1;
    localparam int unsigned CntW    = (lg_credit_to_token_decimation_p > 0) ?
                                      lg_credit_to_token_decimation_p : 1;
    localparam int unsigned CntMax  = TokInc - 1;
    localparam int unsigned LinkW   = width_p + tag_width_lp;

    // ---------------- transmit: credits and round-robin arbitration ----------------
    logic [num_channels_p-1:0][CreditW-1:0] credit_q, credit_d;
    logic [num_channels_p-1:0]              credit_ovf;
    logic [tag_width_lp-1:0]                ptr_q, ptr_d;
    logic [num_channels_p-1:0]              eligible, grant;
    logic                                   grant_found;
    logic [tag_width_lp-1:0]                grant_id;
    logic [LinkW-1:0]                       tx_word;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        eligible    = '0;
        grant       = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            eligible[i] = !core_reset_i && core_v_i[i] && (credit_q[i] != '0);
        end
        // Scan from the priority pointer, wrapping around once.
        for (int unsigned off = 0; off < num_channels_p; off++) begin
            idx = (32'(ptr_q) + off) % num_channels_p;
            if (!grant_found && eligible[tag_width_lp'(idx)]) begin
                grant_found                 = 1'b1;
                grant[tag_width_lp'(idx)]   = 1'b1;
                grant_id                    = tag_width_lp'(idx);
            end
        end
        ptr_d = ptr_q;
        if (grant_found) begin
            ptr_d = (32'(grant_id) + 1 == num_channels_p) ? '0 :
                    tag_width_lp'(32'(grant_id) + 1);
        end
        tx_word = '0;
        if (grant_found) begin
            tx_word = {grant_id, core_data_i[grant_id]};
        end
    end

    assign core_ready_and_o = grant;

    always_comb begin
        int sum;
        sum        = 0;
        credit_d   = credit_q;
        credit_ovf = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            sum = int'(credit_q[i]) + (link_token_i[i] ? int'(TokInc) : 0) - (grant[i] ? 1 : 0);
            credit_ovf[i] = (sum > int'(Depth));
            credit_d[i]   = credit_ovf[i] ? CreditW'(Depth) : CreditW'(sum);
        end
    end

`ifdef BSG_MANYCORE_LINK_SDR_MUX_TX_REG_EN
    logic             link_v_q, link_v_d;
    logic [LinkW-1:0] link_data_q, link_data_d;

    always_comb begin
        link_v_d    = grant_found;
        link_data_d = tx_word;
    end

    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            link_v_q    <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_v_q    <= link_v_d;
            link_data_q <= link_data_d;
        end
    end

    assign link_v_o    = link_v_q;
    assign link_data_o = link_data_q;
`else
    assign link_v_o    = grant_found;
    assign link_data_o = tx_word;
`endif

    // ---------------- receive: per-channel FIFOs ----------------
    logic [width_p-1:0]                     mem_q [num_channels_p][Depth];
    logic [width_p-1:0]                     mem_d [num_channels_p][Depth];
    logic [num_channels_p-1:0][PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [num_channels_p-1:0][CreditW-1:0] count_q, count_d;
    logic [num_channels_p-1:0]              enq, deq, rx_drop;
    logic [tag_width_lp-1:0]                rx_tag;
    logic [width_p-1:0]                     rx_payload;
    logic                                   rx_tag_bad;

    always_comb begin
        logic hit, full;
        hit        = 1'b0;
        full       = 1'b0;
        rx_tag     = link_data_i[LinkW-1 -: tag_width_lp];
        rx_payload = link_data_i[width_p-1:0];
        rx_tag_bad = link_v_i && (32'(rx_tag) >= num_channels_p);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        enq        = '0;
        deq        = '0;
        rx_drop    = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            full   = (count_q[i] == CreditW'(Depth));
            hit    = link_v_i && (32'(rx_tag) == i);
            deq[i] = core_yumi_i[i] && (count_q[i] != '0);
            // A full FIFO still accepts when it is also being drained this cycle.
            enq[i]     = hit && (!full || deq[i]);
            rx_drop[i] = hit && full && !deq[i];
            if (enq[i]) begin
                mem_d[i][wr_ptr_q[i]] = rx_payload;
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (deq[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            if (enq[i] && !deq[i]) begin
                count_d[i] = count_q[i] + 1'b1;
            end else if (!enq[i] && deq[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            core_v_o[i]    = (count_q[i] != '0);
            core_data_o[i] = mem_q[i][rd_ptr_q[i]];
        end
    end

    // ---------------- token return ----------------
    logic [num_channels_p-1:0][CntW-1:0] deq_cnt_q, deq_cnt_d;
    logic [num_channels_p-1:0]           token_q, token_d;

    always_comb begin
        deq_cnt_d = deq_cnt_q;
        token_d   = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            if (deq[i]) begin
                token_d[i]   = (deq_cnt_q[i] == CntW'(CntMax));
                deq_cnt_d[i] = token_d[i] ? '0 : deq_cnt_q[i] + 1'b1;
            end
        end
    end

    assign link_token_o = token_q;

    // ---------------- state ----------------
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            for (int unsigned i = 0; i < num_channels_p; i++) begin
                credit_q[i] <= CreditW'(Depth);
            end
            ptr_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            deq_cnt_q <= '0;
            token_q   <= '0;
        end else begin
            credit_q  <= credit_d;
            ptr_q     <= ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            deq_cnt_q <= deq_cnt_d;
            token_q   <= token_d;
        end
    end

    // Protocol checks: credit overflow, bad tag, enqueue into a full FIFO, yumi on empty.
    a_credit_ovf: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
        credit_ovf == '0);
    a_rx_tag: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
        !rx_tag_bad);
    a_rx_full: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
        rx_drop == '0);
    a_yumi: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
        (core_yumi_i & ~core_v_o) == '0);

endmodule

// File: tb/tb_bsg_manycore_link_sdr_channel_mux.sv
`timescale 1ns/1ps
module tb_bsg_manycore_link_sdr_channel_mux;

    localparam int N      = 2;
    localparam int W      = 16;
    localparam int TW     = 1;
    localparam int LW     = W + TW;
    localparam int DEPTH  = 8;
    localparam int TOKINC = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]        v_i, rdy_o, cv_o, yumi_i, tok_i, tok_o;
    logic [N-1:0][W-1:0] data_i, cdata_o;
    logic                lv_o, lv_i;
    logic [LW-1:0]       ld_o, ld_i;

    bsg_manycore_link_sdr_channel_mux #(
        .num_channels_p                  (N),
        .width_p                         (W),
        .lg_fifo_depth_p                 (3),
        .lg_credit_to_token_decimation_p (1)
    ) dut (
        .core_clk_i       (clk),
        .core_reset_i     (rst),
        .core_v_i         (v_i),
        .core_data_i      (data_i),
        .core_ready_and_o (rdy_o),
        .core_v_o         (cv_o),
        .core_data_o      (cdata_o),
        .core_yumi_i      (yumi_i),
        .link_v_o         (lv_o),
        .link_data_o      (ld_o),
        .link_token_i     (tok_i),
        .link_v_i         (lv_i),
        .link_data_i      (ld_i),
        .link_token_o     (tok_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model state
    int             credit_m[N];
    int             ptr_m;
    logic [W-1:0]   q_m[N][$];
    int             dcnt_m[N];
    logic [N-1:0]   tokp_m;
    bit             model_ok = 0;
    logic           exp_lv_r = 1'b0;
    logic [LW-1:0]  exp_ld_r = '0;

    // Observations of the DUT, cleared whenever reset is seen
    int sent_c[N];
    int tok_c[N];
    int cv_seen[N];
    int tag_log[$];

    always @(negedge clk) begin
        int g;
        int t;
        logic [N-1:0]  exp_rdy;
        logic          e_lv;
        logic [LW-1:0] e_ld;
        g = -1;
        if (!rst) begin
            // Round robin: first requester with credit at or after the pointer, else wrap.
            for (int c = ptr_m; c < N; c++)
                if (g < 0 && v_i[c] && credit_m[c] > 0) g = c;
            for (int c = 0; c < ptr_m; c++)
                if (g < 0 && v_i[c] && credit_m[c] > 0) g = c;
        end
        exp_rdy = '0;
        e_lv    = 1'b0;
        e_ld    = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            e_lv       = 1'b1;
            e_ld       = {TW'(g), data_i[g]};
        end

        if (model_ok) begin
            check("ready", rdy_o, exp_rdy);
`ifdef BSG_MANYCORE_LINK_SDR_MUX_TX_REG_EN
            check("link_v", lv_o, exp_lv_r);
            if (exp_lv_r) check("link_data", ld_o, exp_ld_r);
`else
            check("link_v", lv_o, e_lv);
            check("link_data", ld_o, e_ld);
`endif
            for (int i = 0; i < N; i++) begin
                check("core_v", cv_o[i], q_m[i].size() > 0);
                if (q_m[i].size() > 0) check("core_data", cdata_o[i], q_m[i][0]);
            end
            check("token_out", tok_o, tokp_m);
        end

        if (lv_o === 1'b1) begin
            t = int'(ld_o[LW-1 -: TW]);
            if (t < N) sent_c[t]++;
            tag_log.push_back(t);
        end
        for (int i = 0; i < N; i++) begin
            if (tok_o[i] === 1'b1) tok_c[i]++;
            if (cv_o[i] === 1'b1) cv_seen[i]++;
        end

        if (rst) begin
            for (int i = 0; i < N; i++) begin
                credit_m[i] = DEPTH;
                q_m[i].delete();
                dcnt_m[i]  = 0;
                sent_c[i]  = 0;
                tok_c[i]   = 0;
                cv_seen[i] = 0;
            end
            tag_log.delete();
            ptr_m    = 0;
            tokp_m   = '0;
            model_ok = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                credit_m[i] += (tok_i[i] ? TOKINC : 0) - (g == i ? 1 : 0);
                if (credit_m[i] > DEPTH) credit_m[i] = DEPTH;
            end
            if (g >= 0) ptr_m = (g + 1) % N;
            tokp_m = '0;
            for (int i = 0; i < N; i++) begin
                if (yumi_i[i] && q_m[i].size() > 0) begin
                    void'(q_m[i].pop_front());
                    dcnt_m[i]++;
                    if (dcnt_m[i] == TOKINC) begin
                        dcnt_m[i] = 0;
                        tokp_m[i] = 1'b1;
                    end
                end
            end
            if (lv_i) begin
                t = int'(ld_i[LW-1 -: TW]);
                if (t < N && q_m[t].size() < DEPTH) q_m[t].push_back(ld_i[W-1:0]);
            end
        end
        exp_lv_r = rst ? 1'b0 : e_lv;
        exp_ld_r = rst ? '0 : e_ld;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1; v_i = '0; data_i = '0; tok_i = '0; yumi_i = '0; lv_i = 1'b0; ld_i = '0;
        step(3);
        rst = 1'b0;

        // Credit exhaustion: 8 words, then stall; one token frees exactly 2 more.
        v_i = 2'b01; data_i[0] = 16'h1234;
        step(12);
        check("t1_sent8", sent_c[0], 8);
        check("t1_ready_low", rdy_o[0], 1'b0);
        tok_i[0] = 1'b1; step(1); tok_i[0] = 1'b0;
        step(6);
        check("t1_sent10", sent_c[0], 10);
        v_i = '0;
        do_reset();

        // Round robin alternation.
        v_i = 2'b11; data_i[0] = 16'hAAAA; data_i[1] = 16'h5555;
        step(6);
        v_i = '0;
        step(2);
        check("t2_len", tag_log.size() >= 4, 1'b1);
        if (tag_log.size() >= 4) begin
            check("t2_tag0", tag_log[0], 0);
            check("t2_tag1", tag_log[1], 1);
            check("t2_tag2", tag_log[2], 0);
            check("t2_tag3", tag_log[3], 1);
        end
        check("t2_sent0", sent_c[0], 3);
        check("t2_sent1", sent_c[1], 3);
        do_reset();

        // Isolation: channel 0 out of credit does not block channel 1.
        v_i = 2'b01;
        step(8);
        v_i = 2'b11;
        step(6);
        v_i = '0;
        step(2);
        check("t3_sent0", sent_c[0], 8);
        check("t3_sent1", sent_c[1], 6);
        do_reset();

        // Receive and token return on channel 1.
        lv_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ld_i = {1'b1, 16'h00A0 + 16'(k)};
            step(1);
        end
        lv_i = 1'b0;
        yumi_i = 2'b10;
        step(4);
        yumi_i = '0;
        step(3);
        check("t4_tok1", tok_c[1], 2);
        check("t4_tok0", tok_c[0], 0);
        check("t4_cv0", cv_seen[0], 0);
        do_reset();

        // Full FIFO with simultaneous enqueue and dequeue.
        lv_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ld_i = {1'b0, 16'h0100 + 16'(k)};
            step(1);
        end
        ld_i = {1'b0, 16'h0108};
        yumi_i[0] = 1'b1;
        step(1);
        lv_i = 1'b0;
        yumi_i = '0;
        check("t5_cv", cv_o[0], 1'b1);
        check("t5_occ", q_m[0].size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("t5_order", cdata_o[0], 16'h0101 + 16'(k));
            yumi_i[0] = 1'b1;
            step(1);
        end
        yumi_i = '0;
        check("t5_empty", cv_o[0], 1'b0);
        do_reset();

        // Reset mid-stream.
        v_i = 2'b01; lv_i = 1'b1; ld_i = {1'b1, 16'hBEEF};
        step(3);
        lv_i = 1'b0;
        step(1);
        yumi_i[1] = 1'b1;
        step(1);
        yumi_i = '0; v_i = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_cv", cv_o, 2'b00);
        check("t6_tok", tok_o, 2'b00);
        v_i = 2'b01;
        step(12);
        v_i = '0;
        step(2);
        check("t6_sent8", sent_c[0], 8);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(299) == 0);
            v_i = 2'($urandom);
            for (int i = 0; i < N; i++) begin
                data_i[i] = 16'($urandom);
                tok_i[i]  = (credit_m[i] <= DEPTH - TOKINC) && ($urandom_range(3) == 0);
                yumi_i[i] = (q_m[i].size() > 0) && ($urandom_range(1) == 1);
            end
            t    = $urandom_range(N - 1);
            ld_i = {TW'(t), 16'($urandom)};
            lv_i = ((q_m[t].size() - (yumi_i[t] ? 1 : 0)) < DEPTH) && ($urandom_range(2) != 0);
            step(1);
        end
        rst = 1'b0; v_i = '0; tok_i = '0; yumi_i = '0; lv_i = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
